// File: rtl/bias_bank_loader_pkg.sv
// Shared definitions for the bias bank loader: FSM state encoding,
// default widths and the index-width helper used to size the entry counter.
package bias_bank_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam int BIAS_W_DEFAULT       = 18;
  localparam int N_ADDER_TREE_DEFAULT = 16;

  // Ceiling log2 of n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Entry index width; never narrower than one bit so a one-lane bank still builds.
  function automatic int idx_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bias_bank_loader_entry.sv
// One bias word register with write enable and asynchronous clear.
// Instantiated once per entry per bank by bias_bank_loader.
module bias_entry_reg
  import bias_bank_loader_pkg::*;
#(
  parameter int W = BIAS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture the incoming word when enabled; reset clears the entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bias_bank_loader.sv
// Bias bank loader: collects N_adder_tree bias words from a valid/ready
// stream into a register bank that drives the packed q bus, with framing
// checks on s_last.
// Optional feature macro: BIAS_SHADOW_BANK_EN -- loads fill a shadow bank
// and a commit copies it to the active bank in one cycle, so q and
// bank_valid keep the last committed bank during reloads and after errors.
module bias_bank_loader
  import bias_bank_loader_pkg::*;
#(
  parameter int N_adder_tree = N_ADDER_TREE_DEFAULT,
  parameter int BIAS_W       = BIAS_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BIAS_W-1:0]              s_data,
  input  logic                           s_last,
  output logic [N_adder_tree*BIAS_W-1:0] q,
  output logic                           bank_valid,
  output logic                           load_err
);

  localparam int               IDX_W    = idx_width(N_adder_tree);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_adder_tree - 1);

`ifdef BIAS_SHADOW_BANK_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_s_ready;
  logic                             r_bank_valid;
  logic                             r_load_err;

  logic                             w_write;
  logic                             w_at_last;
  logic                             w_commit;
  logic                             w_frame_err;
  logic [N_adder_tree-1:0]          w_work_we;
  logic [N_adder_tree*BIAS_W-1:0]   w_work_q;

  // r_s_ready is high exactly in LOAD, so it doubles as the "loading" qualifier.
  // A word arriving together with load_start belongs to the aborted load and is dropped.
  assign w_write     = s_valid && r_s_ready && !load_start;
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_commit    = w_write && w_at_last && s_last;
  assign w_frame_err = w_write && (w_at_last ^ s_last);

  // Decode the working-bank write enable for the entry addressed by the index.
  always_comb begin
    w_work_we = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      w_work_we[i] = w_write && (r_idx == IDX_W'(i));
    end
  end

  // Load-control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_s_ready    <= 1'b0;
      r_bank_valid <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (load_start) begin
            r_state      <= ST_LOAD;
            r_idx        <= '0;
            r_s_ready    <= 1'b1;
            r_load_err   <= 1'b0;
            r_bank_valid <= SHADOW_EN ? r_bank_valid : 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            // Restart from entry 0; the in-flight word (if any) is discarded.
            r_idx        <= '0;
            r_bank_valid <= SHADOW_EN ? r_bank_valid : 1'b0;
          end else if (w_commit) begin
            r_state      <= ST_IDLE;
            r_s_ready    <= 1'b0;
            r_bank_valid <= 1'b1;
          end else if (w_frame_err) begin
            r_state      <= ST_ERR;
            r_s_ready    <= 1'b0;
            r_load_err   <= 1'b1;
          end else if (w_write) begin
            // Never reaches past LAST_IDX: the last entry always ends the load.
            r_idx        <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_idx      <= '0;
          r_s_ready  <= 1'b0;
          r_load_err <= 1'b0;
        end
      endcase
    end
  end

  // Working bank: written in arrival order, one entry per accepted word.
  for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_work
    bias_entry_reg #(
      .W (BIAS_W)
    ) u_work (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_work_we[gi]),
      .i_d   (s_data),
      .o_q   (w_work_q[BIAS_W*gi +: BIAS_W])
    );
  end

`ifdef BIAS_SHADOW_BANK_EN
  logic [N_adder_tree*BIAS_W-1:0] w_act_q;

  // Active bank: loads on commit. The final entry is taken straight from the
  // stream because it lands in the working bank in the same cycle.
  for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_active
    logic [BIAS_W-1:0] w_act_d;
    if (gi == N_adder_tree - 1) begin : g_tail
      assign w_act_d = s_data;
    end else begin : g_body
      assign w_act_d = w_work_q[BIAS_W*gi +: BIAS_W];
    end
    bias_entry_reg #(
      .W (BIAS_W)
    ) u_active (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_commit),
      .i_d   (w_act_d),
      .o_q   (w_act_q[BIAS_W*gi +: BIAS_W])
    );
  end

  assign q = w_act_q;
`else
  assign q = w_work_q;
`endif

  assign s_ready    = r_s_ready;
  assign bank_valid = r_bank_valid;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_bias_bank_loader.sv
// Self-checking bench for bias_bank_loader: directed load scenarios with
// random data and random stream gaps, checked every cycle against a
// behavioural bank model.
module tb_bias_bank_loader;

  localparam int N = 16;
  localparam int W = 18;

`ifdef BIAS_SHADOW_BANK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         load_start;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic [N*W-1:0] q;
  logic         bank_valid;
  logic         load_err;

  bias_bank_loader #(
    .N_adder_tree (N),
    .BIAS_W       (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .q          (q),
    .bank_valid (bank_valid),
    .load_err   (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [W-1:0] words    [N];
  logic [W-1:0] m_work   [N];
  logic [W-1:0] m_active [N];
  bit           m_loading;
  bit           m_valid;
  bit           m_err;
  int           m_count;

  // Model: everything cleared.
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_work[i]   = '0;
      m_active[i] = '0;
    end
    m_loading = 1'b0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_count   = 0;
  endtask

  // Model: apply the rules for the inputs presented at one rising edge.
  task automatic model_step(input logic ls, input logic v, input logic [W-1:0] d, input logic l);
    if (ls) begin
      m_loading = 1'b1;
      m_count   = 0;
      m_err     = 1'b0;
      if (!SHADOW) m_valid = 1'b0;
    end else if (m_loading && v) begin
      m_work[m_count] = d;
      if (m_count == N - 1 && l) begin
        m_loading = 1'b0;
        m_valid   = 1'b1;
        for (int i = 0; i < N; i++) m_active[i] = m_work[i];
      end else if (m_count == N - 1 || l) begin
        m_loading = 1'b0;
        m_err     = 1'b1;
      end else begin
        m_count = m_count + 1;
      end
    end
  endtask

  function automatic logic [N*W-1:0] model_q();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*W +: W] = SHADOW ? m_active[i] : m_work[i];
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [N*W-1:0] eq;
    eq = model_q();
    checks++;
    assert (s_ready === m_loading) else begin
      errors++;
      $error("FAIL %s s_ready observed=%0b expected=%0b", tag, s_ready, m_loading);
    end
    checks++;
    assert (bank_valid === m_valid) else begin
      errors++;
      $error("FAIL %s bank_valid observed=%0b expected=%0b", tag, bank_valid, m_valid);
    end
    checks++;
    assert (load_err === m_err) else begin
      errors++;
      $error("FAIL %s load_err observed=%0b expected=%0b", tag, load_err, m_err);
    end
    checks++;
    assert (q === eq) else begin
      errors++;
      $error("FAIL %s q observed=%h expected=%h", tag, q, eq);
    end
  endtask

  task automatic drive(input logic ls, input logic v, input logic [W-1:0] d, input logic l);
    load_start = ls;
    s_valid    = v;
    s_data     = d;
    s_last     = l;
  endtask

  // One clock: model sees the same inputs as the DUT edge, outputs checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step(load_start, s_valid, s_data, s_last);
    #1;
    check_all(tag);
  endtask

  task automatic start(input string tag);
    drive(1'b1, 1'b0, W'(0), 1'b0);
    step(tag);
    drive(1'b0, 1'b0, W'(0), 1'b0);
  endtask

  task automatic new_words();
    for (int i = 0; i < N; i++) words[i] = W'($urandom);
  endtask

  // Send nbeats accepted words, s_last on beat last_at (-1: never), optional random gaps.
  task automatic load_words(input int nbeats, input int last_at, input bit gaps, input string tag);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        int ng;
        ng = int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          drive(1'b0, 1'b0, W'($urandom), 1'($urandom_range(0, 1)));
          step(tag);
        end
      end
      drive(1'b0, 1'b1, words[b], (b == last_at));
      step(tag);
    end
    drive(1'b0, 1'b0, W'(0), 1'b0);
  endtask

  task automatic reset_hold(input string tag);
    @(posedge clk);
    #1;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, W'(0), 1'b0);
    model_reset();
    #1;
    check_all("reset_async");
    reset_hold("reset_hold");

    // Stream activity without load_start is ignored.
    drive(1'b0, 1'b1, W'($urandom), 1'b1);
    step("idle_ignore");
    drive(1'b0, 1'b0, W'(0), 1'b0);
    step("idle_ignore2");

    // Back-to-back full load with the reference first/second/last words.
    new_words();
    words[0]  = 18'h3DF14;
    words[1]  = 18'h0002C;
    words[15] = 18'h00F58;
    start("load_a_start");
    load_words(N, N - 1, 1'b0, "load_a");
    step("load_a_done");

    // Same words with random s_valid gaps.
    start("load_gaps_start");
    load_words(N, N - 1, 1'b1, "load_gaps");
    step("load_gaps_done");

    // A different bank (reload over a committed one).
    new_words();
    start("load_b_start");
    load_words(N, N - 1, 1'b1, "load_b");
    step("load_b_done");

    // Early s_last on beat 7, further words ignored, then recovery.
    new_words();
    start("early_start");
    load_words(8, 7, 1'b0, "early_last");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, W'($urandom), 1'b0);
      step("err_ignore");
    end
    drive(1'b0, 1'b0, W'(0), 1'b0);
    start("err_recover");
    new_words();
    load_words(N, N - 1, 1'b0, "after_err");
    step("after_err_done");

    // Missing s_last on the final beat.
    new_words();
    start("late_start");
    load_words(N, -1, 1'b0, "late_last");
    step("late_last_done");

    // Abort mid-load with a word in the same cycle as load_start.
    new_words();
    start("abort_start");
    load_words(5, -1, 1'b0, "abort_pre");
    drive(1'b1, 1'b1, W'($urandom), 1'b0);
    step("abort");
    new_words();
    load_words(N, N - 1, 1'b0, "abort_reload");
    step("abort_reload_done");

    // Asynchronous reset after 9 beats, then a clean load.
    new_words();
    start("pre_reset_start");
    load_words(9, -1, 1'b0, "pre_reset");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset_midload");
    reset_hold("reset_midload_hold");
    new_words();
    start("post_reset_start");
    load_words(N, N - 1, 1'b1, "post_reset");
    step("post_reset_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bias_bank_loader.md
BIAS_BANK_LOADER -- requirements
Module: bias_bank_loader

Interface
REQ-001 Parameter N_adder_tree, default 16: number of bias entries (adder-tree lanes).
REQ-002 Parameter BIAS_W, default 18: bias word width, two's complement.
REQ-003 clk  input  1  single clock; all state rises on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 load_start  input  1  one-cycle pulse; begins a new bank load.
REQ-006 s_valid  input  1  stream word valid.
REQ-007 s_ready  output  1  stream word accepted when s_valid && s_ready.
REQ-008 s_data  input  BIAS_W  bias word; entry index is implicit in arrival order.
REQ-009 s_last  input  1  marks the final word of a load.
REQ-010 q  output  N_adder_tree*BIAS_W  packed bias bus; entry i at q[BIAS_W*(i+1)-1 : BIAS_W*i].
REQ-011 bank_valid  output  1  q holds a complete, error-free bank.
REQ-012 load_err  output  1  sticky framing error for the current load.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD and ERR.
REQ-014 IDLE: s_ready=0; load_start -> LOAD, index counter cleared to 0, load_err cleared.
REQ-015 LOAD: s_ready=1; each accepted word is written to working entry [index]; index increments by 1.
REQ-016 Accepted word at index N_adder_tree-1 with s_last=1 -> commit, IDLE, bank_valid=1 on the next cycle.
REQ-017 s_last=1 at index < N_adder_tree-1, or s_last=0 at index N_adder_tree-1 -> ERR, load_err=1 on the next cycle; index never wraps.
REQ-018 ERR: s_ready=0; remains until load_start, which behaves exactly as in IDLE.
REQ-019 load_start in LOAD SHALL abort the load and restart at index 0; a word accepted in the same cycle is discarded.
REQ-020 s_data SHALL be stored unmodified (no sign extension, no rounding); q bits are register outputs with no combinational path from any input.
REQ-021 Without shadow banking, the working bank drives q directly; bank_valid deasserts on the cycle after load_start and stays 0 until commit.
REQ-022 Throughput SHALL be one word per cycle; a full load takes N_adder_tree accepted beats.

Reset
REQ-023 rst_n low SHALL force IDLE, index=0, s_ready=0, bank_valid=0, load_err=0 and every q entry to 0, asynchronously.
REQ-024 Reset asserted mid-load SHALL discard the partial load; no entry retains pre-reset data.

Configuration
REQ-025 Macro BIAS_SHADOW_BANK_EN, when defined, SHALL add a second BIAS_W x N_adder_tree register bank: loads write the shadow bank, q is driven from the active bank, and commit copies shadow to active in one cycle.
REQ-026 With BIAS_SHADOW_BANK_EN, bank_valid SHALL stay 1 during a reload and after an error, and q SHALL keep the last committed bank.
REQ-027 Without BIAS_SHADOW_BANK_EN, behaviour SHALL follow REQ-021.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the BIAS_W default and the index-width function clog2(N_adder_tree).
REQ-029 One sub-module, bias_entry_reg (one BIAS_W register with write enable and async clear), SHALL be instantiated per entry per bank.

Verification
REQ-030 Load 16 words 0x3DF14, 0x0002C, ... 0x00F58, s_last on word 15, no gaps -> bank_valid=1 one cycle after beat 15; q matches word-for-word.
REQ-031 Same load with s_valid deasserted on random cycles -> identical q; 16 beats counted only on accepted handshakes.
REQ-032 s_last on beat 7 -> load_err=1, s_ready=0, further s_valid ignored; load_start recovers and clears load_err.
REQ-033 Beat 15 with s_last=0 -> ERR; q entry 15 holds beat-15 data (no shadow) or previous bank (shadow).
REQ-034 rst_n low after 9 beats -> all q=0, bank_valid=0, IDLE immediately; next full load succeeds.
REQ-035 BIAS_SHADOW_BANK_EN defined: commit bank A, reload bank B -> q=A with bank_valid=1 until B commits, then q=B on the next cycle.
